// File: rtl/ub_pwm_pkg.sv
// ---------------------------------------------------------------------------
// ub_pwm_pkg
// Shared constants for the ub_pwm_bank PWM block: the register address map
// and the legal ranges of the bank parameters.
//
// Address map (relative to the bank's CHANNELS parameter):
//   DUTY_BASE + i            duty register of channel i (0 .. CHANNELS-1)
//   CHANNELS + PERIOD_OFS    PERIOD register
//   CHANNELS + PRESCALE_OFS  PRESCALE register (only with UB_PWM_PRESCALER_EN)
//   anything above           ignored
// ---------------------------------------------------------------------------
package ub_pwm_pkg;

    // Register map
    localparam int DUTY_BASE    = 0;
    localparam int PERIOD_OFS   = 0;
    localparam int PRESCALE_OFS = 1;

    // Prescaler register and counter width
    localparam int PRESCALE_W   = 8;

    // Legal parameter ranges
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 8;
    localparam int WIDTH_MIN    = 4;
    localparam int WIDTH_MAX    = 16;

endpackage

// File: rtl/ub_pwm_chan.sv
// ---------------------------------------------------------------------------
// ub_pwm_chan
// One PWM channel: a duty shadow register written by the host, a duty active
// register that is reloaded only at the period wrap, and the registered
// compare that produces the PWM level.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena_i      run enable; the output register holds while low
//   wr_sel_i   write strobe already decoded for this channel
//   wr_data_i  duty value to write
//   wrap_i     period wrap step; active duty reloads from shadow
//   cnt_i      shared period counter
//   pwm_o      registered PWM output, high while cnt < active duty
// ---------------------------------------------------------------------------
module ub_pwm_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             wr_sel_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             wrap_i,
    input  logic [WIDTH-1:0] cnt_i,
    output logic             pwm_o
);

    logic [WIDTH-1:0] dutyShadow_q, dutyShadow_d;
    logic [WIDTH-1:0] dutyActive_q, dutyActive_d;
    logic             pwm_q, pwm_d;

    // The active duty is loaded from the next-state shadow value so that a
    // write landing on the wrap cycle is the one that takes effect.
    always_comb begin
        dutyShadow_d = dutyShadow_q;
        dutyActive_d = dutyActive_q;
        pwm_d        = pwm_q;
        if (wr_sel_i) begin
            dutyShadow_d = wr_data_i;
        end
        if (wrap_i) begin
            dutyActive_d = dutyShadow_d;
        end
        if (ena_i) begin
            pwm_d = (cnt_i < dutyActive_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dutyShadow_q <= '0;
            dutyActive_q <= '0;
            pwm_q        <= 1'b0;
        end else begin
            dutyShadow_q <= dutyShadow_d;
            dutyActive_q <= dutyActive_d;
            pwm_q        <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/ub_pwm_bank.sv
// ---------------------------------------------------------------------------
// ub_pwm_bank
// Bank of CHANNELS PWM outputs sharing one period counter. Duty and period
// registers are double-buffered: host writes land in shadow registers and
// are copied to the active registers only at the period wrap, so a running
// waveform never glitches.
//
// Optional feature: define UB_PWM_PRESCALER_EN to add an 8-bit PRESCALE
// register (address CHANNELS+1) that slows the counter to one step every
// PRESCALE+1 enabled clocks. Without the macro the counter steps every
// enabled clock and PRESCALE writes are ignored.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   ena          run enable; counter, prescaler and outputs hold while low
//   wr_en        register write strobe
//   wr_addr      register address (duty 0..CHANNELS-1, PERIOD, PRESCALE)
//   wr_data      register write data
//   pwm_out      registered PWM outputs, one per channel
//   period_tick  high for the single cycle of each period wrap step
// ---------------------------------------------------------------------------
module ub_pwm_bank
    import ub_pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [WIDTH-1:0]    wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    // Reject parameter sets the address map or counter cannot support.
    if ((CHANNELS < CHANNELS_MIN) || (CHANNELS > CHANNELS_MAX) ||
        (WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX) ||
        (ADDR_W < $clog2(CHANNELS + 2))) begin : g_param_check
        $error("ub_pwm_bank: illegal CHANNELS/WIDTH/ADDR_W combination");
    end

    localparam logic [ADDR_W-1:0] PERIOD_ADDR = ADDR_W'(CHANNELS + PERIOD_OFS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] periodShadow_q, periodShadow_d;
    logic [WIDTH-1:0] periodActive_q, periodActive_d;
    logic             step;
    logic             wrap;
    logic             wrPeriod;

    assign wrPeriod = wr_en && (wr_addr == PERIOD_ADDR);

`ifdef UB_PWM_PRESCALER_EN
    localparam logic [ADDR_W-1:0] PRESCALE_ADDR = ADDR_W'(CHANNELS + PRESCALE_OFS);

    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pscCnt_q, pscCnt_d;
    logic                  wrPrescale;
    logic                  pscTick;

    assign wrPrescale = wr_en && (wr_addr == PRESCALE_ADDR);

    // PRESCALE is not double-buffered. The >= compare keeps the prescaler
    // from running away when PRESCALE is lowered below the current count.
    assign pscTick = (pscCnt_q >= prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        pscCnt_d   = pscCnt_q;
        if (wrPrescale) begin
            prescale_d = PRESCALE_W'(wr_data);
        end
        if (ena) begin
            pscCnt_d = pscTick ? '0 : pscCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q <= '0;
            pscCnt_q   <= '0;
        end else begin
            prescale_q <= prescale_d;
            pscCnt_q   <= pscCnt_d;
        end
    end

    assign step = ena && pscTick;
`else
    assign step = ena;
`endif

    // The wrap is the step on which the counter sits at the active period.
    // Because the active period only changes at the wrap, the counter can
    // never be left above a freshly shortened period.
    assign wrap = step && (cnt_q == periodActive_q);

    always_comb begin
        cnt_d          = cnt_q;
        periodShadow_d = periodShadow_q;
        periodActive_d = periodActive_q;
        if (wrPeriod) begin
            periodShadow_d = wr_data;
        end
        if (wrap) begin
            cnt_d          = '0;
            periodActive_d = periodShadow_d;
        end else if (step) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            periodShadow_q <= '1;
            periodActive_q <= '1;
        end else begin
            cnt_q          <= cnt_d;
            periodShadow_q <= periodShadow_d;
            periodActive_q <= periodActive_d;
        end
    end

    assign period_tick = wrap;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic chanWr;

        assign chanWr = wr_en && (wr_addr == ADDR_W'(DUTY_BASE + i));

        ub_pwm_chan #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena_i     (ena),
            .wr_sel_i  (chanWr),
            .wr_data_i (wr_data),
            .wrap_i    (wrap),
            .cnt_i     (cnt_q),
            .pwm_o     (pwm_out[i])
        );
    end

endmodule
